// File: rtl/mult_share_arbiter_if.sv
// Bundle between the requesters, the shared-multiplier arbiter and the multiplier pipe.
// The slave modport is the arbiter's view. The master modport is the view of the feeders and the multiplier.
interface mult_share_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int PSUM_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [PSUM_WIDTH-1:0]         rsp_data;
    logic                          mul_valid;
    logic [DATA_WIDTH-1:0]         mul_a;
    logic [DATA_WIDTH-1:0]         mul_b;
    logic [PSUM_WIDTH-1:0]         mul_rlst;
    logic                          mul_rlst_vld;

    modport slave (
        input  req_valid, req_a, req_b, mul_rlst, mul_rlst_vld,
        output req_ready, rsp_valid, rsp_data, mul_valid, mul_a, mul_b
    );

    modport master (
        output req_valid, req_a, req_b, mul_rlst, mul_rlst_vld,
        input  req_ready, rsp_valid, rsp_data, mul_valid, mul_a, mul_b
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Shares one fixed-latency multiplier among NUM_REQ requesters and routes each product back to its owner.
// Define MULT_ARB_FIXED_PRIO_EN to select fixed priority (lowest index wins) instead of round-robin.
module mult_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int PSUM_WIDTH = 32,
    parameter int MULT_LAT   = 5
) (
    input  logic                  s_clk,
    input  logic                  s_rst_n,
    mult_share_arbiter_if.slave   bus,
    output logic                  busy,
    output logic                  err
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MULT_LAT + 2);

    localparam logic [0:0] ST_DRAIN = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]                   state;
    logic [CNT_W-1:0]             drain_cnt;
    logic                         grant_found;
    logic [IDX_W-1:0]             grant_idx;
    logic                         transfer;
    logic [MULT_LAT:0]            tag_vld;
    logic [MULT_LAT:0][IDX_W-1:0] tag_idx;
    logic                         head_vld;
    logic [IDX_W-1:0]             head_idx;

`ifdef MULT_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[IDX_W'(i)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest valid index after rr_ptr is the one left standing.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge s_clk) begin
        if (!s_rst_n) begin
            rr_ptr <= IDX_W'(NUM_REQ - 1);
        end else if (transfer) begin
            rr_ptr <= grant_idx;
        end
    end
`endif

    assign bus.req_ready = (state == ST_RUN && grant_found) ? (NUM_REQ'(1) << grant_idx) : '0;
    assign transfer      = |(bus.req_valid & bus.req_ready);

    // DRAIN covers enough cycles for anything issued before reset to leave the multiplier.
    always_ff @(posedge s_clk) begin
        if (!s_rst_n) begin
            state     <= ST_DRAIN;
            drain_cnt <= CNT_W'(MULT_LAT + 1);
        end else if (state == ST_DRAIN) begin
            drain_cnt <= drain_cnt - 1'b1;
            if (drain_cnt == CNT_W'(1)) begin
                state <= ST_RUN;
            end
        end
    end

    always_ff @(posedge s_clk) begin
        if (!s_rst_n) begin
            bus.mul_valid <= 1'b0;
            bus.mul_a     <= '0;
            bus.mul_b     <= '0;
        end else begin
            bus.mul_valid <= transfer;
            if (transfer) begin
                bus.mul_a <= bus.req_a[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                bus.mul_b <= bus.req_b[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Stage 0 mirrors the issue register, so the head lines up with the cycle the result is due.
    always_ff @(posedge s_clk) begin
        if (!s_rst_n) begin
            tag_vld <= '0;
            tag_idx <= '0;
        end else begin
            tag_vld <= {tag_vld[MULT_LAT-1:0], transfer};
            tag_idx <= {tag_idx[MULT_LAT-1:0], grant_idx};
        end
    end

    assign head_vld = tag_vld[MULT_LAT];
    assign head_idx = tag_idx[MULT_LAT];

    always_ff @(posedge s_clk) begin
        if (!s_rst_n) begin
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
            err           <= 1'b0;
        end else begin
            bus.rsp_valid <= '0;
            if (state == ST_RUN) begin
                if (head_vld && bus.mul_rlst_vld) begin
                    bus.rsp_valid <= NUM_REQ'(1) << head_idx;
                    bus.rsp_data  <= bus.mul_rlst;
                end
                if (head_vld != bus.mul_rlst_vld) begin
                    err <= 1'b1;
                end
            end
        end
    end

    assign busy = (state == ST_DRAIN) | (|tag_vld) | bus.mul_valid;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural fixed-latency multiplier.
// A table of single-requester vectors is followed by hand-written multi-cycle sequences.
module tb_mult_share_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int PSUM_WIDTH = 32;
    localparam int MULT_LAT   = 5;

    typedef struct {
        int          idx;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [31:0] prod;
    } vec_t;

    logic s_clk = 1'b0;
    logic s_rst_n;
    logic busy;
    logic err;
    logic spur;

    int checks = 0;
    int errors = 0;

    vec_t vecs [6];

    mult_share_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .PSUM_WIDTH(PSUM_WIDTH)) bus ();

    mult_share_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .PSUM_WIDTH(PSUM_WIDTH), .MULT_LAT(MULT_LAT)
    ) dut (
        .s_clk   (s_clk),
        .s_rst_n (s_rst_n),
        .bus     (bus),
        .busy    (busy),
        .err     (err)
    );

    always #5 s_clk = ~s_clk;

    // Behavioural multiplier: not reset, so pre-reset issues still come back during DRAIN.
    logic [MULT_LAT-1:0]   pipe_vld = '0;
    logic [PSUM_WIDTH-1:0] pipe_data [MULT_LAT];

    always @(posedge s_clk) begin
        pipe_vld     <= {pipe_vld[MULT_LAT-2:0], bus.mul_valid};
        pipe_data[0] <= {{(PSUM_WIDTH-DATA_WIDTH){bus.mul_a[DATA_WIDTH-1]}}, bus.mul_a}
                      * {{(PSUM_WIDTH-DATA_WIDTH){bus.mul_b[DATA_WIDTH-1]}}, bus.mul_b};
        for (int i = 1; i < MULT_LAT; i++) pipe_data[i] <= pipe_data[i-1];
    end

    assign bus.mul_rlst     = pipe_data[MULT_LAT-1];
    assign bus.mul_rlst_vld = pipe_vld[MULT_LAT-1] | spur;

    function automatic logic [3:0] oh(input int i);
        oh = 4'(1) << i;
    endfunction

    task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] a_pk, input logic [31:0] b_pk);
        bus.req_valid = valid;
        bus.req_a     = a_pk;
        bus.req_b     = b_pk;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Called at the negedge of the transfer cycle; follows the op through to its response.
    task automatic followResult(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [31:0] prod);
        int early;
        early = 0;
        @(negedge s_clk);
        applyStimulus(4'h0, 32'h0, 32'h0);
        #1;
        checkOutput("issue_valid", 32'(bus.mul_valid), 32'h1);
        checkOutput("issue_a", 32'(bus.mul_a), 32'(a));
        checkOutput("issue_b", 32'(bus.mul_b), 32'(b));
        if (bus.rsp_valid != 4'h0) early++;
        for (int n = 2; n <= 6; n++) begin
            @(negedge s_clk);
            #1;
            if (bus.rsp_valid != 4'h0) early++;
            if (n == 3) checkOutput("busy_inflight", 32'(busy), 32'h1);
        end
        checkOutput("rsp_early", 32'(early), 32'h0);
        @(negedge s_clk);
        #1;
        checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(oh(idx)));
        checkOutput("rsp_data", bus.rsp_data, prod);
        @(negedge s_clk);
        #1;
        checkOutput("rsp_single", 32'(bus.rsp_valid), 32'h0);
        checkOutput("rsp_hold", bus.rsp_data, prod);
        checkOutput("busy_idle", 32'(busy), 32'h0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int wait_cnt;
        int rsp_cnt;
        int err_seen;

        vecs[0] = '{0, 8'h03, 8'hFB, 32'hFFFF_FFF1};
        vecs[1] = '{1, 8'h7F, 8'h7F, 32'h0000_3F01};
        vecs[2] = '{2, 8'h80, 8'h80, 32'h0000_4000};
        vecs[3] = '{1, 8'hFF, 8'h01, 32'hFFFF_FFFF};
        vecs[4] = '{2, 8'h00, 8'h55, 32'h0000_0000};
        vecs[5] = '{3, 8'h80, 8'h7F, 32'hFFFF_C080};

        s_rst_n = 1'b0;
        spur    = 1'b0;
        applyStimulus(4'h0, 32'h0, 32'h0);
        repeat (3) @(negedge s_clk);
        #1;
        checkOutput("rst_ready", 32'(bus.req_ready), 32'h0);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        checkOutput("rst_rsp_data", bus.rsp_data, 32'h0);
        checkOutput("rst_mul_valid", 32'(bus.mul_valid), 32'h0);
        checkOutput("rst_mul_a", 32'(bus.mul_a), 32'h0);
        checkOutput("rst_mul_b", 32'(bus.mul_b), 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h1);

        // Leave reset with req0 waiting; the grant must wait out the DRAIN window.
        @(negedge s_clk);
        s_rst_n = 1'b1;
        applyStimulus(4'b0001, 32'h03, 32'hFB);
        #1;
        wait_cnt = 0;
        while (bus.req_ready == 4'h0 && wait_cnt < 50) begin
            @(negedge s_clk);
            #1;
            wait_cnt++;
        end
        checkOutput("drain_len", 32'(wait_cnt), 32'(MULT_LAT + 1));
        checkOutput("first_grant", 32'(bus.req_ready), 32'h1);
        followResult(0, 8'h03, 8'hFB, 32'hFFFF_FFF1);

        for (int i = 0; i < 6; i++) begin
            @(negedge s_clk);
            applyStimulus(oh(vecs[i].idx), 32'(vecs[i].a) << (8 * vecs[i].idx), 32'(vecs[i].b) << (8 * vecs[i].idx));
            #1;
            checkOutput("vec_grant", 32'(bus.req_ready), 32'(oh(vecs[i].idx)));
            followResult(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].prod);
        end

`ifdef MULT_ARB_FIXED_PRIO_EN
        // req0 and req2 contend; req2 only wins once req0 drops.
        for (int c = 0; c < 5; c++) begin
            @(negedge s_clk);
            applyStimulus((c < 4) ? 4'b0101 : 4'b0100, 32'h0, 32'h0);
            #1;
            checkOutput("fixed_grant", 32'(bus.req_ready), (c < 4) ? 32'h1 : 32'h4);
        end
        @(negedge s_clk);
        applyStimulus(4'h0, 32'h0, 32'h0);
        repeat (12) @(negedge s_clk);
`else
        // All four requesters valid: pointer sits at 3 after the table, so grants go 0,1,2,3,0...
        for (int c = 0; c < 16; c++) begin
            @(negedge s_clk);
            if (c < 8) applyStimulus(4'hF, 32'h0403_0201, 32'h0202_0202);
            else       applyStimulus(4'h0, 32'h0, 32'h0);
            #1;
            if (c < 8) checkOutput("rr_grant", 32'(bus.req_ready), 32'(oh(c % 4)));
            if (c >= 7 && c < 15) begin
                checkOutput("rr_rsp_valid", 32'(bus.rsp_valid), 32'(oh((c - 7) % 4)));
                checkOutput("rr_rsp_data", bus.rsp_data, 32'(2 * ((c - 7) % 4 + 1)));
            end
            if (c == 15) checkOutput("rr_rsp_end", 32'(bus.rsp_valid), 32'h0);
        end
`endif
        checkOutput("err_clean", 32'(err), 32'h0);

        // A result with no tag in flight raises the sticky error and produces no response.
        @(negedge s_clk);
        spur = 1'b1;
        @(negedge s_clk);
        spur = 1'b0;
        #1;
        checkOutput("spur_err", 32'(err), 32'h1);
        checkOutput("spur_no_rsp", 32'(bus.rsp_valid), 32'h0);
        rsp_cnt = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge s_clk);
            #1;
            if (bus.rsp_valid != 4'h0) rsp_cnt++;
        end
        checkOutput("err_sticky", 32'(err), 32'h1);
        checkOutput("spur_no_rsp_later", 32'(rsp_cnt), 32'h0);

        @(negedge s_clk);
        s_rst_n = 1'b0;
        @(negedge s_clk);
        s_rst_n = 1'b1;
        repeat (8) @(negedge s_clk);
        #1;
        checkOutput("err_cleared", 32'(err), 32'h0);
        checkOutput("busy_after_drain", 32'(busy), 32'h0);

        // Three ops in flight, then reset; their results land inside DRAIN and must vanish quietly.
        for (int c = 0; c < 3; c++) begin
            @(negedge s_clk);
            applyStimulus(4'b0111, 32'h0005_0403, 32'h0007_0605);
            #1;
            checkOutput("mid_grant_any", 32'(bus.req_ready != 4'h0), 32'h1);
        end
        @(negedge s_clk);
        applyStimulus(4'h0, 32'h0, 32'h0);
        @(negedge s_clk);
        s_rst_n = 1'b0;
        @(negedge s_clk);
        s_rst_n = 1'b1;
        rsp_cnt  = 0;
        err_seen = 0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (bus.rsp_valid != 4'h0) rsp_cnt++;
            if (err) err_seen++;
            @(negedge s_clk);
        end
        #1;
        checkOutput("rst_mid_no_rsp", 32'(rsp_cnt), 32'h0);
        checkOutput("rst_mid_no_err", 32'(err_seen), 32'h0);
        checkOutput("rst_mid_busy", 32'(busy), 32'h0);

        applyStimulus(4'b0010, 32'h0000_0900, 32'h0000_F700);
        #1;
        checkOutput("post_rst_grant", 32'(bus.req_ready), 32'h2);
        followResult(1, 8'h09, 8'hF7, 32'hFFFF_FFAF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
